// File: rtl/jenc_poll_ctrl.sv
// jenc_poll_ctrl: periodic encoder poll/receive supervisor; define JENC_POLL_STATS_EN to build the timeout/length/overrun counters
module jenc_poll_ctrl #(
    parameter int POLL_DIV  = 10000,
    parameter int TIMEOUT   = 5000,
    parameter int FRAME_LEN = 40,
    parameter int MAX_MISS  = 3
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic        en,
    input  logic        tx_ack,
    input  logic        rxdv,
    input  logic        clear_fault,
    output logic        tx_req,
    output logic        sample_valid,
    output logic        busy,
    output logic        fault,
    output logic [31:0] frame_cnt,
    output logic [15:0] timeout_cnt,
    output logic [15:0] len_err_cnt,
    output logic [15:0] overrun_cnt
);
    localparam int PW = $clog2(POLL_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RX, RX} state_t;
    state_t        state;
    logic [PW-1:0] poll_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [6:0]    len;
    logic [3:0]    miss;
    logic [3:0]    miss_nxt;
    logic          tick;
    logic          tmo_hit;
    logic          tmo_evt;
    logic          fin_ok;
    logic          fin_bad;
    logic          fail;
    logic          fault_nxt;
    assign tick      = poll_cnt == PW'(POLL_DIV - 1);
    assign tmo_hit   = tmo_cnt == TW'(TIMEOUT - 1);
    assign tmo_evt   = tmo_hit && ((state == REQ && !tx_ack) || (state == WAIT_RX && !rxdv));
    assign fail      = tmo_evt || fin_bad;
    assign busy      = state != IDLE;
    assign miss_nxt  = fail ? (clear_fault ? 4'd1 : miss + 4'(miss != 4'hF)) : (fin_ok || clear_fault) ? 4'd0 : miss;
    assign fault_nxt = (fault && !clear_fault) || (fail && miss_nxt >= 4'(MAX_MISS));
    // free-running poll timer, independent of enable and transaction state
    always_ff @(posedge c or negedge rst_n)
        if (!rst_n) poll_cnt <= '0;
        else poll_cnt <= tick ? '0 : poll_cnt + PW'(1);
    // transaction sequencer; frame verdict is registered one cycle after RX exit
    always_ff @(posedge c or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            tx_req  <= 1'b0;
            tmo_cnt <= '0;
            len     <= '0;
            fin_ok  <= 1'b0;
            fin_bad <= 1'b0;
        end else begin
            fin_ok  <= 1'b0;
            fin_bad <= 1'b0;
            case (state)
                IDLE:
                    if (tick && en) begin
                        state   <= REQ;
                        tx_req  <= 1'b1;
                        tmo_cnt <= '0;
                    end
                REQ:
                    if (tx_ack) begin
                        state   <= WAIT_RX;
                        tx_req  <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        state  <= IDLE;
                        tx_req <= 1'b0;
                    end else tmo_cnt <= tmo_cnt + TW'(1);
                WAIT_RX:
                    if (rxdv) begin
                        state <= RX;
                        len   <= 7'd1;
                    end else if (tmo_hit) state <= IDLE;
                    else tmo_cnt <= tmo_cnt + TW'(1);
                RX:
                    if (rxdv) len <= len + 7'(len != 7'd127);
                    else begin
                        state   <= IDLE;
                        fin_ok  <= len == 7'(FRAME_LEN);
                        fin_bad <= len != 7'(FRAME_LEN);
                    end
            endcase
        end
    // frame result, consecutive-miss tracking and sticky fault
    always_ff @(posedge c or negedge rst_n)
        if (!rst_n) begin
            sample_valid <= 1'b0;
            frame_cnt    <= '0;
            miss         <= '0;
            fault        <= 1'b0;
        end else begin
            sample_valid <= fin_ok;
            frame_cnt    <= frame_cnt + 32'(fin_ok);
            miss         <= miss_nxt;
            fault        <= fault_nxt;
        end
`ifdef JENC_POLL_STATS_EN
    // saturating diagnostic counters
    always_ff @(posedge c or negedge rst_n)
        if (!rst_n) begin
            timeout_cnt <= '0;
            len_err_cnt <= '0;
            overrun_cnt <= '0;
        end else begin
            if (tmo_evt && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
            if (fin_bad && len_err_cnt != 16'hFFFF) len_err_cnt <= len_err_cnt + 16'd1;
            if (tick && busy && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
        end
`else
    assign timeout_cnt = '0;
    assign len_err_cnt = '0;
    assign overrun_cnt = '0;
`endif
endmodule

// File: tb/tb_jenc_poll_ctrl.sv
// tb_jenc_poll_ctrl: transaction-level randomized bench for jenc_poll_ctrl
module tb_jenc_poll_ctrl;
    localparam int POLL_DIV  = 100;
    localparam int TIMEOUT   = 50;
    localparam int FRAME_LEN = 40;
    localparam int MAX_MISS  = 3;
`ifdef JENC_POLL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic c = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic tx_ack = 1'b0;
    logic rxdv = 1'b0;
    logic clear_fault = 1'b0;
    logic tx_req, sample_valid, busy, fault;
    logic [31:0] frame_cnt;
    logic [15:0] timeout_cnt, len_err_cnt, overrun_cnt;
    int checks = 0;
    int errors = 0;
    int m_frames, m_tmo, m_lerr, m_ovr, m_miss;
    bit m_fault;
    string nm[5] = '{"frame_cnt", "timeout_cnt", "len_err_cnt", "overrun_cnt", "fault"};

    jenc_poll_ctrl #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT), .FRAME_LEN(FRAME_LEN), .MAX_MISS(MAX_MISS)) dut (
        .c(c), .rst_n(rst_n), .en(en), .tx_ack(tx_ack), .rxdv(rxdv), .clear_fault(clear_fault),
        .tx_req(tx_req), .sample_valid(sample_valid), .busy(busy), .fault(fault),
        .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt), .len_err_cnt(len_err_cnt), .overrun_cnt(overrun_cnt)
    );

    always #5 c = ~c;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void m_reset();
        m_frames = 0; m_tmo = 0; m_lerr = 0; m_ovr = 0; m_miss = 0; m_fault = 1'b0;
    endfunction

    function automatic void m_fail();
        m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        if (m_miss >= MAX_MISS) m_fault = 1'b1;
    endfunction

    // One poll transaction: ack after d cycles (d>=TIMEOUT: never), rxdv after g cycles
    // (g>=TIMEOUT: never), burst of l bytes. Expected results come from the outcome rules.
    task automatic run_txn(input int d, input int g, input int l, input bit clr, input bit drop_en);
        int n, bl;
        logic [63:0] a[5], e[5];
        n = 0;
        while (tx_req !== 1'b1 && n < 3 * POLL_DIV) begin
            rxdv = noise();
            @(negedge c); n++;
        end
        rxdv = 1'b0;
        checks++;
        if (tx_req !== 1'b1) begin
            errors++; $display("FAIL req_start: tx_req=%b, wanted 1 within %0d cycles", tx_req, 3 * POLL_DIV);
            return;
        end
        if (drop_en) en = 1'b0;
        if (d >= TIMEOUT) begin
            n = 0;
            while (tx_req === 1'b1 && n < TIMEOUT + 10) begin
                rxdv = noise();
                clear_fault = clr && n == TIMEOUT - 1;
                @(negedge c); n++;
            end
            clear_fault = 1'b0; rxdv = 1'b0;
            checks++;
            if (n != TIMEOUT) begin errors++; $display("FAIL req_timeout: tx_req high %0d cycles, wanted %0d", n, TIMEOUT); end
            bl = TIMEOUT;
            if (clr) begin m_miss = 0; m_fault = 1'b0; end
            m_tmo++; m_fail();
            repeat (2) begin
                @(negedge c); checks++;
                if (sample_valid !== 1'b0) begin errors++; $display("FAIL sv_after_req_timeout: got %b wanted 0", sample_valid); end
            end
        end else begin
            for (int i = 0; i < d; i++) begin rxdv = noise(); @(negedge c); end
            rxdv = 1'b0;
            checks++;
            if (tx_req !== 1'b1) begin errors++; $display("FAIL req_hold: tx_req=%b wanted 1 at ack", tx_req); end
            tx_ack = 1'b1; @(negedge c); tx_ack = 1'b0;
            checks++;
            if (tx_req !== 1'b0) begin errors++; $display("FAIL req_drop: tx_req=%b wanted 0 after ack", tx_req); end
            if (g >= TIMEOUT) begin
                n = 0;
                while (busy === 1'b1 && n < TIMEOUT + 10) begin @(negedge c); n++; end
                checks++;
                if (n != TIMEOUT) begin errors++; $display("FAIL rx_timeout: busy %0d cycles in wait, wanted %0d", n, TIMEOUT); end
                bl = d + 1 + TIMEOUT;
                m_tmo++; m_fail();
                repeat (2) begin
                    @(negedge c); checks++;
                    if (sample_valid !== 1'b0) begin errors++; $display("FAIL sv_after_rx_timeout: got %b wanted 0", sample_valid); end
                end
            end else begin
                repeat (g) @(negedge c);
                rxdv = 1'b1;
                repeat (l) @(negedge c);
                rxdv = 1'b0;
                @(negedge c);
                checks++;
                if (busy !== 1'b0 || sample_valid !== 1'b0) begin
                    errors++; $display("FAIL rx_exit: busy=%b sample_valid=%b, wanted 0 0", busy, sample_valid);
                end
                @(negedge c);
                checks++;
                if (sample_valid !== (l == FRAME_LEN)) begin
                    errors++; $display("FAIL sample_valid: len %0d got %b wanted %b", l, sample_valid, l == FRAME_LEN);
                end
                @(negedge c);
                checks++;
                if (sample_valid !== 1'b0) begin errors++; $display("FAIL sv_width: got %b wanted 0", sample_valid); end
                bl = d + g + l + 2;
                if (l == FRAME_LEN) begin m_frames++; m_miss = 0; end
                else begin m_lerr++; m_fail(); end
            end
        end
        m_ovr += bl / POLL_DIV;
        a = '{frame_cnt, timeout_cnt, len_err_cnt, overrun_cnt, fault};
        e = '{m_frames, STATS ? m_tmo : 0, STATS ? m_lerr : 0, STATS ? m_ovr : 0, m_fault};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a[i] !== e[i]) begin errors++; $display("FAIL %s: got %0d wanted %0d", nm[i], a[i], e[i]); end
        end
    endtask

    task automatic test_reset();
        int n;
        en = 1'b1;
        repeat (3) @(negedge c);
        checks++;
        if ({tx_req, sample_valid, busy, fault, frame_cnt, timeout_cnt, len_err_cnt, overrun_cnt} !== '0) begin
            errors++; $display("FAIL reset_state: outputs %h wanted 0",
                {tx_req, sample_valid, busy, fault, frame_cnt, timeout_cnt, len_err_cnt, overrun_cnt});
        end
        m_reset();
        rst_n = 1'b1;
        n = 0;
        do begin @(posedge c); #1; n++; end while (tx_req !== 1'b1 && n < 2 * POLL_DIV);
        checks++;
        if (n != POLL_DIV) begin errors++; $display("FAIL first_req: tx_req after %0d cycles, wanted %0d", n, POLL_DIV); end
        @(negedge c);
        run_txn(3, 2, FRAME_LEN, 1'b0, 1'b0);
    endtask

    task automatic test_good_frames();
        repeat (3) run_txn(3, 0, FRAME_LEN, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(TIMEOUT, 0, 0, 1'b0, 1'b0);
        run_txn(3, TIMEOUT, 0, 1'b0, 1'b0);
        run_txn(TIMEOUT - 1, TIMEOUT - 1, FRAME_LEN, 1'b0, 1'b0);
    endtask

    task automatic test_len_err_fault();
        run_txn(3, 2, FRAME_LEN - 1, 1'b0, 1'b0);
        run_txn(3, 2, FRAME_LEN + 1, 1'b0, 1'b0);
        run_txn(TIMEOUT, 0, 0, 1'b0, 1'b0);
        run_txn(3, 2, FRAME_LEN, 1'b0, 1'b0);
        clear_fault = 1'b1; @(negedge c); clear_fault = 1'b0;
        m_miss = 0; m_fault = 1'b0;
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL clear_fault: fault=%b wanted 0", fault); end
    endtask

    task automatic test_clear_collision();
        run_txn(3, 2, 7, 1'b0, 1'b0);
        run_txn(TIMEOUT, 0, 0, 1'b0, 1'b0);
        run_txn(TIMEOUT, 0, 0, 1'b1, 1'b0);
        run_txn(3, 2, 90, 1'b0, 1'b0);
        run_txn(TIMEOUT, 0, 0, 1'b0, 1'b0);
        run_txn(3, 2, FRAME_LEN, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        run_txn(45, 45, 127, 1'b0, 1'b0);
        run_txn(40, 30, 60, 1'b0, 1'b0);
    endtask

    task automatic test_en_low();
        int n;
        run_txn(3, 2, FRAME_LEN, 1'b0, 1'b1);
        n = 0;
        repeat (2 * POLL_DIV) begin @(negedge c); if (tx_req !== 1'b0 || busy !== 1'b0) n++; end
        checks++;
        if (n != 0) begin errors++; $display("FAIL en_low_idle: %0d busy/req cycles with en low, wanted 0", n); end
        en = 1'b1;
        run_txn(3, 2, FRAME_LEN, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int d, g, l, bl, r;
            bit clr;
            do begin
                r = $urandom_range(0, 9);
                d = (r == 0) ? TIMEOUT + int'($urandom_range(0, 5)) : int'($urandom_range(0, TIMEOUT - 1));
                g = (r == 1) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
                l = $urandom_range(0, 1) ? FRAME_LEN : int'($urandom_range(1, 130));
                bl = (d >= TIMEOUT) ? TIMEOUT : (g >= TIMEOUT) ? d + 1 + TIMEOUT : d + g + l + 2;
            end while (bl % POLL_DIV > 95);
            clr = (r == 0) && $urandom_range(0, 1) == 1;
            run_txn(d, g, l, clr, 1'b0);
        end
    endtask

    task automatic test_reset_mid_rx();
        int n;
        n = 0;
        while (tx_req !== 1'b1 && n < 3 * POLL_DIV) begin @(negedge c); n++; end
        tx_ack = 1'b1; @(negedge c); tx_ack = 1'b0;
        rxdv = 1'b1;
        repeat (20) @(negedge c);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_req, sample_valid, busy, fault, frame_cnt, timeout_cnt, len_err_cnt, overrun_cnt} !== '0) begin
            errors++; $display("FAIL reset_mid_rx: outputs %h wanted 0",
                {tx_req, sample_valid, busy, fault, frame_cnt, timeout_cnt, len_err_cnt, overrun_cnt});
        end
        @(negedge c);
        rxdv = 1'b0;
        rst_n = 1'b1;
        m_reset();
        n = 0;
        do begin @(posedge c); #1; n++; end while (tx_req !== 1'b1 && n < 2 * POLL_DIV);
        checks++;
        if (n != POLL_DIV) begin errors++; $display("FAIL req_after_reset: tx_req after %0d cycles, wanted %0d", n, POLL_DIV); end
        @(negedge c);
        run_txn(3, 2, FRAME_LEN, 1'b0, 1'b0);
    endtask

    initial begin
        m_reset();
        test_reset();
        test_good_frames();
        test_timeout();
        test_len_err_fault();
        test_clear_collision();
        test_overrun();
        test_en_low();
        test_random();
        test_reset_mid_rx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
